// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: data-bus request/response, access size,
// and the execute/memory pipeline bundles.
// Latency: n/a (types only). Backpressure: n/a.
package memory_access_pkg;

  // Access size; the encoding is log2 of the byte count.
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] aluout;
    logic [63:0] writedata;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic [4:0]  dst;
    msize_t      msize;
    logic        msigned;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] aluout;
    logic [63:0] readdata;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic [4:0]  dst;
  } memory_data_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } ma_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: load extract/extend and store lane shift/strobe.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; both paths are evaluated every cycle.
module mem_align
  import memory_access_pkg::*;
(
  input  logic [63:0] ld_data_i,
  input  logic [2:0]  ld_off_i,
  input  msize_t      ld_size_i,
  input  logic        ld_signed_i,
  output logic [63:0] ld_value_o,
  input  logic [63:0] st_wdata_i,
  input  logic [2:0]  st_off_i,
  input  msize_t      st_size_i,
  output logic [63:0] st_data_o,
  output logic [7:0]  st_strobe_o
);

  logic [63:0] ld_shifted;
  logic [7:0]  st_mask;

  // Load: move the addressed bytes down to lane 0, then zero/sign-extend.
  always_comb begin
    ld_shifted = ld_data_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      MSIZE1:  ld_value_o = {{56{ld_signed_i & ld_shifted[7]}}, ld_shifted[7:0]};
      MSIZE2:  ld_value_o = {{48{ld_signed_i & ld_shifted[15]}}, ld_shifted[15:0]};
      MSIZE4:  ld_value_o = {{32{ld_signed_i & ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_value_o = ld_shifted;
    endcase
  end

  // Store: shift write data into its byte lanes and build the matching strobe.
  always_comb begin
    case (st_size_i)
      MSIZE1:  st_mask = 8'h01;
      MSIZE2:  st_mask = 8'h03;
      MSIZE4:  st_mask = 8'h0F;
      default: st_mask = 8'hFF;
    endcase
    st_data_o   = st_wdata_i << {st_off_i, 3'b000};
    st_strobe_o = st_mask << st_off_i;
  end

endmodule

// File: rtl/memory_access.sv
// Registered memory stage: issues one data-bus request per load/store and aligns the result.
// Latency: 1 cycle for non-memory ops; data_ok in cycle k gives dataM in cycle k+1.
// Backpressure: stallM holds upstream from op acceptance until the cycle data_ok arrives.
module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output logic          stallM,
  output memory_data_t  dataM,
  input  dbus_resp_t    dresp,
  output dbus_req_t     dreq
);

  ma_state_t    state_q, state_d;
  memory_data_t pend_q, pend_d;      // pass-through fields of the op on the bus
  logic         signed_q, signed_d;  // load sign-extension flag of that op
  dbus_req_t    dreq_q, dreq_d;
  memory_data_t dataM_q, dataM_d;

  memory_data_t pass_e;
  logic [63:0]  ld_value;
  logic [63:0]  st_data;
  logic [7:0]   st_strobe;

  // Load side works on the held request; store side on the incoming op.
  mem_align u_align (
    .ld_data_i   (dresp.data),
    .ld_off_i    (dreq_q.addr[2:0]),
    .ld_size_i   (dreq_q.size),
    .ld_signed_i (signed_q),
    .ld_value_o  (ld_value),
    .st_wdata_i  (dataE.writedata),
    .st_off_i    (dataE.aluout[2:0]),
    .st_size_i   (dataE.msize),
    .st_data_o   (st_data),
    .st_strobe_o (st_strobe)
  );

  // Writeback bundle built from the execute bundle, readdata zero.
  always_comb begin
    pass_e          = '0;
    pass_e.valid    = 1'b1;
    pass_e.instr    = dataE.instr;
    pass_e.pc       = dataE.pc;
    pass_e.aluout   = dataE.aluout;
    pass_e.memread  = dataE.memread;
    pass_e.memwrite = dataE.memwrite;
    pass_e.memtoreg = dataE.memtoreg;
    pass_e.regwrite = dataE.regwrite;
    pass_e.dst      = dataE.dst;
  end

  // Next-state, request and stall logic; dataM defaults to a bubble.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    signed_d = signed_q;
    dreq_d   = dreq_q;
    dataM_d  = '0;
    stallM   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dataE.valid) begin
          if (dataE.memread || dataE.memwrite) begin
            stallM        = 1'b1;
            state_d       = S_BUSY;
            pend_d        = pass_e;
            signed_d      = dataE.msigned;
            dreq_d.valid  = 1'b1;
            dreq_d.addr   = dataE.aluout;
            dreq_d.size   = dataE.msize;
            dreq_d.strobe = st_strobe;
            dreq_d.data   = st_data;
          end else begin
            dataM_d = pass_e;
          end
        end
      end
      S_BUSY: begin
        // Request stays frozen in dreq_q until the bus answers.
        stallM = !dresp.data_ok;
        if (dresp.data_ok) begin
          dataM_d          = pend_q;
          dataM_d.readdata = pend_q.memread ? ld_value : 64'd0;
          state_d          = S_IDLE;
          dreq_d           = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers; reset abandons any bus transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      signed_q <= 1'b0;
      dreq_q   <= '0;
      dataM_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      signed_q <= signed_d;
      dreq_q   <= dreq_d;
      dataM_q  <= dataM_d;
    end
  end

  assign dataM = dataM_q;
  assign dreq  = dreq_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a transaction-level reference model.
// Latency: n/a. Backpressure: holds dataE while stallM is high.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  dbus_resp_t    dresp;
  logic          stallM;
  memory_data_t  dataM;
  dbus_req_t     dreq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk    (clk),
    .reset  (reset),
    .dataE  (dataE),
    .stallM (stallM),
    .dataM  (dataM),
    .dresp  (dresp),
    .dreq   (dreq)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int nbytes(input msize_t s);
    return 1 << int'(s);
  endfunction

  function automatic logic [63:0] m_extract(input logic [63:0] d, input logic [2:0] off,
                                            input msize_t s, input logic sg);
    logic [63:0] v;
    int n;
    v = '0;
    n = nbytes(s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(int'(off)+i) +: 8];
    if (sg && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic dbus_req_t m_req(input execute_data_t e);
    dbus_req_t r;
    int off;
    r = '0;
    off = int'(e.aluout[2:0]);
    r.valid = 1'b1;
    r.addr  = e.aluout;
    r.size  = e.msize;
    for (int i = 0; i < nbytes(e.msize); i++) r.strobe[off+i] = 1'b1;
    r.data  = e.writedata << (8*off);
    return r;
  endfunction

  function automatic memory_data_t m_wb(input execute_data_t e, input logic [63:0] rd);
    memory_data_t w;
    w = '0;
    w.valid = 1'b1;  w.instr = e.instr;  w.pc = e.pc;  w.aluout = e.aluout;
    w.readdata = rd; w.memread = e.memread; w.memwrite = e.memwrite;
    w.memtoreg = e.memtoreg; w.regwrite = e.regwrite; w.dst = e.dst;
    return w;
  endfunction

  logic          m_busy = 1'b0;
  execute_data_t m_op   = '0;
  memory_data_t  m_out  = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_op   = '0;
      m_out  = '0;
    end else if (m_busy) begin
      if (dresp.data_ok) begin
        m_out  = m_wb(m_op, m_op.memread ?
                 m_extract(dresp.data, m_op.aluout[2:0], m_op.msize, m_op.msigned) : 64'd0);
        m_busy = 1'b0;
      end else begin
        m_out = '0;
      end
    end else if (dataE.valid && (dataE.memread || dataE.memwrite)) begin
      m_busy = 1'b1;
      m_op   = dataE;
      m_out  = '0;
    end else if (dataE.valid) begin
      m_out = m_wb(dataE, 64'd0);
    end else begin
      m_out = '0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = m_busy ? !dresp.data_ok : (dataE.valid && (dataE.memread || dataE.memwrite));
    check("model_stallM", 256'(stallM), 256'(exp_stall));
    check("model_dreq", 256'(dreq), m_busy ? 256'(m_req(m_op)) : 256'd0);
    check("model_dataM", 256'(dataM), 256'(m_out));
  end

  // ---------------- stimulus helpers ----------------
  function automatic execute_data_t mk(input logic [63:0] addr, input msize_t sz, input logic sg,
                                       input logic rd, input logic wr, input logic [63:0] wd,
                                       input logic [4:0] dst);
    execute_data_t e;
    e = '0;
    e.valid = 1'b1; e.instr = 32'hF940_0000 ^ addr[31:0]; e.pc = 64'h4000_0000 + addr;
    e.aluout = addr; e.writedata = wd; e.memread = rd; e.memwrite = wr;
    e.memtoreg = rd; e.regwrite = !wr; e.dst = dst; e.msize = sz; e.msigned = sg;
    return e;
  endfunction

  task automatic run_mem(input execute_data_t op, input int k, input logic [63:0] rdata,
                         input execute_data_t nxt, output dbus_req_t req1, output memory_data_t wb);
    dataE = op;
    dresp = '0;
    req1  = '0;
    for (int c = 0; c <= k; c++) begin
      if (c == k) begin
        dresp.data_ok = 1'b1;
        dresp.data    = rdata;
      end
      @(negedge clk);
      check("op_stallM", 256'(stallM), 256'(c < k));
      check("op_dreq_valid", 256'(dreq.valid), 256'(c >= 1));
      if (c == 1) req1 = dreq;
      step();
    end
    dataE = nxt;
    dresp = '0;
    @(negedge clk);
    wb = dataM;
    check("op_wb_valid", 256'(dataM.valid), 256'd1);
    check("op_dreq_dropped", 256'(dreq.valid), 256'd0);
  endtask

  typedef struct {
    logic [63:0] addr; msize_t sz; logic sg; logic [63:0] d; int k; logic [63:0] exp;
  } ld_vec_t;
  typedef struct {
    logic [63:0] addr; msize_t sz; logic [63:0] wd; int k; logic [63:0] exp_d; logic [7:0] exp_s;
  } st_vec_t;

  ld_vec_t      lv[6];
  st_vec_t      sv[4];
  dbus_req_t    r1;
  memory_data_t wb;

  initial begin
    lv[0] = '{64'h1003, MSIZE1, 1'b1, 64'h00000000_80000000, 3, 64'hFFFFFFFF_FFFFFF80};
    lv[1] = '{64'h1003, MSIZE1, 1'b0, 64'h00000000_80000000, 3, 64'h00000000_00000080};
    lv[2] = '{64'h1004, MSIZE4, 1'b1, 64'h89ABCDEF_01234567, 2, 64'hFFFFFFFF_89ABCDEF};
    lv[3] = '{64'h1002, MSIZE2, 1'b1, 64'h89ABCDEF_01234567, 1, 64'h00000000_00000123};
    lv[4] = '{64'h1000, MSIZE8, 1'b1, 64'hFEDCBA98_76543210, 4, 64'hFEDCBA98_76543210};
    lv[5] = '{64'h1006, MSIZE2, 1'b0, 64'hFEDCBA98_76543210, 2, 64'h00000000_0000FEDC};
    sv[0] = '{64'h2006, MSIZE2, 64'hBEEF,                 5, 64'hBEEF0000_00000000, 8'hC0};
    sv[1] = '{64'h2001, MSIZE1, 64'h5A,                   1, 64'h00000000_00005A00, 8'h02};
    sv[2] = '{64'h2004, MSIZE4, 64'h11223344,             2, 64'h11223344_00000000, 8'hF0};
    sv[3] = '{64'h2000, MSIZE8, 64'h01234567_89ABCDEF,    1, 64'h01234567_89ABCDEF, 8'hFF};

    // Reset with random inputs, valid low.
    reset = 1'b0;
    dataE = '0;
    dresp = '0;
    for (int i = 0; i < 4; i++) begin
      dataE = mk({$urandom, $urandom}, msize_t'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 1'($urandom), {$urandom, $urandom}, 5'($urandom));
      dataE.valid = 1'b0;
      dresp.data_ok = 1'($urandom);
      dresp.data    = {$urandom, $urandom};
      @(negedge clk);
      check("rst_dataM_valid", 256'(dataM.valid), 256'd0);
      check("rst_dreq_valid", 256'(dreq.valid), 256'd0);
      check("rst_stallM", 256'(stallM), 256'd0);
      step();
    end
    dataE = '0;
    dresp = '0;
    reset = 1'b1;
    step();

    // ALU pass-through; a stray data_ok while idle must be ignored.
    dataE = mk(64'h1234, MSIZE1, 1'b0, 1'b0, 1'b0, 64'h0, 5'd5);
    dresp.data_ok = 1'b1;
    @(negedge clk);
    check("alu_stallM", 256'(stallM), 256'd0);
    step();
    dataE = '0;
    dresp = '0;
    @(negedge clk);
    check("alu_valid", 256'(dataM.valid), 256'd1);
    check("alu_aluout", 256'(dataM.aluout), 256'h1234);
    check("alu_dst", 256'(dataM.dst), 256'd5);
    check("alu_readdata", 256'(dataM.readdata), 256'd0);
    step();

    // Loads.
    for (int i = 0; i < 6; i++) begin
      run_mem(mk(lv[i].addr, lv[i].sz, lv[i].sg, 1'b1, 1'b0, 64'h0, 5'(i + 1)),
              lv[i].k, lv[i].d, '0, r1, wb);
      check("ld_readdata", 256'(wb.readdata), 256'(lv[i].exp));
      step();
    end

    // Stores.
    for (int i = 0; i < 4; i++) begin
      run_mem(mk(sv[i].addr, sv[i].sz, 1'b0, 1'b0, 1'b1, sv[i].wd, 5'd0),
              sv[i].k, 64'hDEAD_BEEF_DEAD_BEEF, '0, r1, wb);
      check("st_data", 256'(r1.data), 256'(sv[i].exp_d));
      check("st_strobe", 256'(r1.strobe), 256'(sv[i].exp_s));
      check("st_addr", 256'(r1.addr), 256'(sv[i].addr));
      check("st_readdata", 256'(wb.readdata), 256'd0);
      step();
    end

    // Back-to-back: load with immediate data_ok, then an ALU op.
    run_mem(mk(64'h1001, MSIZE1, 1'b0, 1'b1, 1'b0, 64'h0, 5'd9), 1, 64'h0000_0000_0000_7700,
            mk(64'h0777, MSIZE1, 1'b0, 1'b0, 1'b0, 64'h0, 5'd10), r1, wb);
    check("b2b_ld_readdata", 256'(wb.readdata), 256'h77);
    check("b2b_alu_stallM", 256'(stallM), 256'd0);
    step();
    dataE = '0;
    @(negedge clk);
    check("b2b_alu_valid", 256'(dataM.valid), 256'd1);
    check("b2b_alu_aluout", 256'(dataM.aluout), 256'h0777);
    step();
    @(negedge clk);
    check("b2b_no_dup", 256'(dataM.valid), 256'd0);
    step();

    // Reset while the bus transaction is outstanding.
    dataE = mk(64'h3000, MSIZE8, 1'b0, 1'b1, 1'b0, 64'h0, 5'd3);
    step();
    step();
    check("mid_dreq_busy", 256'(dreq.valid), 256'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_dreq_async_drop", 256'(dreq.valid), 256'd0);
    dataE = '0;
    step();
    reset = 1'b1;
    step();
    dataE = mk(64'h55, MSIZE1, 1'b0, 1'b0, 1'b0, 64'h0, 5'd7);
    @(negedge clk);
    check("post_rst_stallM", 256'(stallM), 256'd0);
    step();
    dataE = '0;
    @(negedge clk);
    check("post_rst_valid", 256'(dataM.valid), 256'd1);
    check("post_rst_aluout", 256'(dataM.aluout), 256'h55);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
